// File: rtl/spi_mem_if_if.sv
// Bundles the SPI pins and the memory-side bus of the SPI-to-memory bridge.
// The slave modport is the bridge's view; the master modport is the surrounding system.
interface spi_mem_if_if;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_ss;
    logic [3:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;
    logic       mem_wrt;

    modport slave (
        input  spi_clk,
        input  spi_mosi,
        input  spi_ss,
        input  mem_din,
        output spi_miso,
        output mem_addr,
        output mem_dout,
        output mem_wrt
    );

    modport master (
        output spi_clk,
        output spi_mosi,
        output spi_ss,
        output mem_din,
        input  spi_miso,
        input  mem_addr,
        input  mem_dout,
        input  mem_wrt
    );
endinterface

// File: rtl/spi_mem_if.sv
// Oversampling SPI mode-0 slave giving an external master read/write access to a 16 x 8 memory.
// The first byte is a command (bit 7 = write, bits 3:0 = start address); data bytes auto-increment.
module spi_mem_if (
    input logic         clk,
    input logic         rst,
    spi_mem_if_if.slave bus
);

    typedef enum logic [1:0] {CMD, WRITE, READ} state_t;

    state_t     state;
    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic [1:0] ss_sync;
    logic       sclk_dly;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift;
    logic [3:0] addr;
    logic [7:0] dout;
    logic       wrt;

    logic       sclk_s;
    logic       mosi_s;
    logic       ss_s;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       byte_done;
    logic [7:0] rx_next;

    assign sclk_s    = sclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign ss_s      = ss_sync[1];
    assign sclk_rise = sclk_s & ~sclk_dly;
    assign sclk_fall = ~sclk_s & sclk_dly;
    assign rx_next   = {rx_shift, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);

    assign bus.spi_miso = tx_shift[7];
    assign bus.mem_addr = addr;
    assign bus.mem_dout = dout;
    assign bus.mem_wrt  = wrt;

    // mosi shares the clock's synchronizer depth so the sampled bit lines up with the detected rise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            ss_sync   <= 2'b00;
            sclk_dly  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], bus.spi_clk};
            mosi_sync <= {mosi_sync[0], bus.spi_mosi};
            ss_sync   <= {ss_sync[0], bus.spi_ss};
            sclk_dly  <= sclk_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= CMD;
            bit_cnt  <= 3'd0;
            rx_shift <= 7'd0;
            tx_shift <= 8'd0;
            addr     <= 4'd0;
            dout     <= 8'd0;
            wrt      <= 1'b0;
        end else begin
            wrt <= 1'b0;
            if (!ss_s) begin
                // Deselect wins over any edge seen in the same cycle; a partial byte is dropped
                state    <= CMD;
                bit_cnt  <= 3'd0;
                rx_shift <= 7'd0;
                tx_shift <= 8'd0;
            end else begin
                if (wrt) begin
                    addr <= addr + 4'd1;
                end
                if (sclk_rise) begin
                    rx_shift <= rx_next[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    case (state)
                        CMD: begin
                            addr  <= rx_next[3:0];
                            state <= rx_next[7] ? WRITE : READ;
                        end
                        WRITE: begin
                            dout <= rx_next;
                            wrt  <= 1'b1;
                        end
                        READ: begin
                            addr <= addr + 4'd1;
                        end
                        default: state <= CMD;
                    endcase
                end
                // The fall after a completed read byte loads the next word so its MSB leads the next byte
                if (sclk_fall) begin
                    if ((bit_cnt == 3'd0) && (state == READ)) begin
                        tx_shift <= bus.mem_din;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_if.sv
// Directed bench for spi_mem_if: drives SPI mode-0 transfers and checks the memory bus and MISO.
module tb_spi_mem_if;

    logic       clk;
    logic       rst;
    logic       use_tie;
    logic [7:0] mem_arr [16];
    int         n_cmp;
    int         n_err;
    int         wr_cnt;
    logic [3:0] wr_addr [8];
    logic [7:0] wr_data [8];
    int         wr_base;
    logic [7:0] rx_byte;

    spi_mem_if_if bus ();

    spi_mem_if dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_din = use_tie ? 8'hE1 : mem_arr[bus.mem_addr];

    // Records every clk cycle in which the write strobe is high
    always @(negedge clk) begin
        if (bus.mem_wrt === 1'b1) begin
            if (wr_cnt < 8) begin
                wr_addr[wr_cnt] = bus.mem_addr;
                wr_data[wr_cnt] = bus.mem_dout;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Shifts the top nbits of tx_val, sampling MISO just before each rising edge
    task automatic spi_xfer(input logic [7:0] tx_val, input int nbits, output logic [7:0] miso_bits);
        miso_bits = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = tx_val[7 - i];
            repeat (5) @(negedge clk);
            miso_bits[7 - i] = bus.spi_miso;
            bus.spi_clk = 1'b1;
            repeat (5) @(negedge clk);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic deselect();
        repeat (3) @(negedge clk);
        bus.spi_ss = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        wr_cnt  = 0;
        use_tie = 1'b1;
        for (int i = 0; i < 16; i++) mem_arr[i] = 8'h00;
        mem_arr[2]  = 8'h3C;
        mem_arr[15] = 8'h96;
        mem_arr[0]  = 8'h11;
        mem_arr[1]  = 8'hC3;

        // Reset with random activity on the inputs
        rst          = 1'b0;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_ss   = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.spi_clk  = 1'($urandom_range(0, 1));
            bus.spi_mosi = 1'($urandom_range(0, 1));
            bus.spi_ss   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("rst_addr", {4'h0, bus.mem_addr}, 8'h00);
        check("rst_dout", bus.mem_dout, 8'h00);
        check("rst_wrt", {7'd0, bus.mem_wrt}, 8'h00);
        check("rst_miso", {7'd0, bus.spi_miso}, 8'h00);

        bus.spi_ss  = 1'b0;
        bus.spi_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.spi_clk  = 1'($urandom_range(0, 1));
            bus.spi_mosi = 1'($urandom_range(0, 1));
        end
        bus.spi_clk = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_addr", {4'h0, bus.mem_addr}, 8'h00);
        check("idle_dout", bus.mem_dout, 8'h00);
        check("idle_miso", {7'd0, bus.spi_miso}, 8'h00);
        check("idle_wrcnt", 8'(wr_cnt), 8'd0);

        // Read with mem_din tied to E1
        $display("[TB] read test");
        bus.spi_ss = 1'b1;
        spi_xfer(8'h0A, 8, rx_byte);
        check("rd_cmd_miso", rx_byte, 8'h00);
        check("rd_cmd_addr", {4'h0, bus.mem_addr}, 8'h0A);
        spi_xfer(8'h00, 8, rx_byte);
        check("rd_data_miso", rx_byte, 8'hE1);
        check("rd_data_addr", {4'h0, bus.mem_addr}, 8'h0B);
        check("rd_no_wrt", 8'(wr_cnt), 8'd0);
        deselect();
        use_tie = 1'b0;

        // Multi-byte write crossing the top address
        $display("[TB] write test");
        bus.spi_ss = 1'b1;
        spi_xfer(8'h8E, 8, rx_byte);
        spi_xfer(8'hA5, 8, rx_byte);
        check("wr_miso_zero", rx_byte, 8'h00);
        spi_xfer(8'h5A, 8, rx_byte);
        check("wr_pulses", 8'(wr_cnt), 8'd2);
        check("wr0_addr", {4'h0, wr_addr[0]}, 8'h0E);
        check("wr0_data", wr_data[0], 8'hA5);
        check("wr1_addr", {4'h0, wr_addr[1]}, 8'h0F);
        check("wr1_data", wr_data[1], 8'h5A);
        check("wr_final_addr", {4'h0, bus.mem_addr}, 8'h00);
        deselect();
        check("wr_dout_hold", bus.mem_dout, 8'h5A);

        // Abort a write data byte after 5 bits
        $display("[TB] abort test");
        wr_base    = wr_cnt;
        bus.spi_ss = 1'b1;
        spi_xfer(8'h83, 8, rx_byte);
        spi_xfer(8'hFF, 5, rx_byte);
        bus.spi_ss = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_wrt", 8'(wr_cnt - wr_base), 8'd0);
        check("abort_addr", {4'h0, bus.mem_addr}, 8'h03);
        bus.spi_ss = 1'b1;
        spi_xfer(8'h02, 8, rx_byte);
        check("abort_cmd_addr", {4'h0, bus.mem_addr}, 8'h02);
        spi_xfer(8'h00, 8, rx_byte);
        check("abort_rd_data", rx_byte, 8'h3C);
        check("abort_rd_addr", {4'h0, bus.mem_addr}, 8'h03);
        deselect();

        // Read burst wrapping from F to 0
        $display("[TB] burst test");
        bus.spi_ss = 1'b1;
        spi_xfer(8'h0F, 8, rx_byte);
        check("burst_addr_f", {4'h0, bus.mem_addr}, 8'h0F);
        spi_xfer(8'h00, 8, rx_byte);
        check("burst_d0", rx_byte, 8'h96);
        check("burst_addr_0", {4'h0, bus.mem_addr}, 8'h00);
        spi_xfer(8'h00, 8, rx_byte);
        check("burst_d1", rx_byte, 8'h11);
        check("burst_addr_1", {4'h0, bus.mem_addr}, 8'h01);
        spi_xfer(8'h00, 8, rx_byte);
        check("burst_d2", rx_byte, 8'hC3);
        check("burst_addr_2", {4'h0, bus.mem_addr}, 8'h02);
        check("burst_no_wrt", 8'(wr_cnt - wr_base), 8'd0);
        deselect();

        // Asynchronous reset during bit 4 of a write data byte
        $display("[TB] async reset test");
        wr_base    = wr_cnt;
        bus.spi_ss = 1'b1;
        spi_xfer(8'h84, 8, rx_byte);
        check("ar_cmd_addr", {4'h0, bus.mem_addr}, 8'h04);
        spi_xfer(8'hFF, 3, rx_byte);
        bus.spi_mosi = 1'b1;
        repeat (5) @(negedge clk);
        bus.spi_clk = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("ar_addr", {4'h0, bus.mem_addr}, 8'h00);
        check("ar_dout", bus.mem_dout, 8'h00);
        check("ar_wrt", {7'd0, bus.mem_wrt}, 8'h00);
        check("ar_miso", {7'd0, bus.spi_miso}, 8'h00);
        @(negedge clk);
        bus.spi_clk = 1'b0;
        bus.spi_ss  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("ar_no_wrt", 8'(wr_cnt - wr_base), 8'd0);
        check("ar_post_addr", {4'h0, bus.mem_addr}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_mem_if.md
Name:
spi_mem_if

Overview:
- SPI slave bridge that lets an external SPI master read and write a small 16 x 8-bit register file or memory.
- Everything runs in the system clock domain; the SPI pins are oversampled.
- The first byte of each transaction is a command: direction bit plus 4-bit start address.
- Following bytes are data, with the address auto-incrementing after each byte.

Parameters:
- none (address width is fixed at 4 bits, data width at 8 bits)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- spi_clk  in  1  SPI serial clock from master (mode 0: idle low)
- spi_mosi  in  1  master-out data, MSB first, sampled on spi_clk rising edge
- spi_miso  out  1  slave-out data, MSB first, changes on spi_clk falling edge
- spi_ss  in  1  slave select, active-high; low = idle/abort
- mem_addr  out  4  memory address
- mem_din  in  8  read data from memory, valid at most 2 clk after mem_addr changes
- mem_dout  out  8  write data to memory
- mem_wrt  out  1  write strobe, one clk wide

Behaviour:
Reset (rst low, async):
- mem_addr=0, mem_dout=0, mem_wrt=0, spi_miso=0.
- Bit counter=0, rx/tx shift registers=0, state=CMD.

Synchronisation:
- spi_clk, spi_mosi and spi_ss each pass through a 2-flop synchronizer.
- Rise and fall of spi_clk are detected from the synchronized copy plus one delay flop.
- Master requirement: spi_clk high and low times each >= 4 clk periods.

Transaction framing:
- spi_ss low: state forced to CMD, bit counter=0, spi_miso=0, mem_wrt=0.
- mem_addr and mem_dout hold their values while spi_ss is low.
- Deasserting spi_ss mid-byte discards the partial byte with no write.

Bit handling:
- Each detected spi_clk rise while spi_ss is high shifts synchronized mosi into the LSB of the rx register.
- The same rise increments the 3-bit bit counter.
- The 8th rise (counter wraps to 0) is the byte-complete event E.

States:
- CMD: at E, command byte c is taken.
  - mem_addr <= c[3:0].
  - c[7]=1 -> WRITE; c[7]=0 -> READ.
  - c[6:4] are ignored.
- WRITE: at E, mem_dout <= received byte and mem_wrt=1 for exactly one clk at the current mem_addr.
  - On the next clk, mem_wrt=0 and mem_addr <= mem_addr+1 (4-bit wrap, F->0).
  - Stays in WRITE.
- READ: at E, mem_addr <= mem_addr+1 (wrap). Stays in READ.

MISO:
- spi_miso = tx[7].
- On each detected spi_clk fall while spi_ss is high:
  - if the bit counter is 0 (byte boundary) and state is READ, tx <= mem_din (parallel load);
  - otherwise tx shifts left with 0 fill.
- Effect: MSB of mem_din at the new address is on spi_miso before the first rise of the next byte, and the address is advanced for the following byte.
- spi_miso is 0 throughout the command byte and during WRITE.

Simultaneity:
- An spi_ss fall has priority over a same-cycle clock edge.
- Only one mem_wrt pulse per byte.

Test Plan:
- Reset: rst low with random inputs -> mem_addr=0, mem_dout=0, mem_wrt=0, spi_miso=0; these hold after release while spi_ss=0.
- Read: mem_din tied to 0xE1; ss=1, shift 0x0A then 0x00 -> mem_addr=0xA after the first byte, no mem_wrt.
  - Second byte: spi_miso shows 1,1,1,0,0,0,0,1 on successive rises.
  - mem_addr=0xB after the second byte.
- Multi-byte write: ss=1, shift 0x8E, 0xA5, 0x5A -> mem_wrt pulse with addr=0xE, dout=0xA5.
  - Then mem_wrt pulse with addr=0xF, dout=0x5A; final mem_addr=0x0 (wrap).
  - Exactly two one-clk pulses.
- Abort: ss=1, shift 0x83, then 0xFF cut after 5 bits with ss=0 -> no mem_wrt.
  - Next transaction starts in CMD: 0x02 reads address 2.
- Read burst wrap: command 0x0F, three data bytes -> mem_addr sequence F,0,1,2.
  - mem_din changes per address are reflected on spi_miso for each byte.
- Async reset mid-transfer: rst low during bit 4 of a write data byte -> outputs go to reset values immediately, no mem_wrt.
